// File: rtl/mdio_arbiter.sv
// mdio_arbiter
//   Round-robin arbiter that shares one MDIO serial engine among NUM_REQ
//   clients. Each client posts a single register read or write at a time.
//   The arbiter grants the engine, runs its request/ready handshake, returns
//   read data with a one-cycle done pulse, and aborts a hung engine after
//   TIMEOUT_CYCLES. Lives entirely in the 2.5 MHz MDIO clock domain.
//
// Ports
//   clock, reset        MDIO-domain clock, asynchronous active-high reset
//   req[i]              level request from client i, held until done[i]
//   req_wr[i]           1 = write, 0 = read (sampled at grant)
//   req_addr[5i+:5]     register address (sampled at grant)
//   req_wdata[16i+:16]  write data (sampled at grant)
//   done[i]             one-cycle completion pulse to the granted client
//   err                 valid with done; 1 = transaction aborted by timeout
//   rd_data             read result, valid with done, held until next done
//   busy                high from grant through the done cycle
//   grant_id            current or most recently granted client
//   mdio_addr, mdio_wr_data, mdio_rd_request, mdio_wr_request  to engine
//   mdio_ready, mdio_rd_data                                   from engine
module mdio_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ-1:0]      req_wr,
  input  logic [5*NUM_REQ-1:0]    req_addr,
  input  logic [16*NUM_REQ-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]      done,
  output logic                    err,
  output logic [15:0]             rd_data,
  output logic                    busy,
  output logic [2:0]              grant_id,
  output logic [4:0]              mdio_addr,
  output logic [15:0]             mdio_wr_data,
  output logic                    mdio_rd_request,
  output logic                    mdio_wr_request,
  input  logic                    mdio_ready,
  input  logic [15:0]             mdio_rd_data
);

  localparam int               CNT_W       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [2:0]       LAST_IDX    = 3'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_FINISH
  } state_t;

  state_t               r_state,    w_state;
  logic [2:0]           r_ptr,      w_ptr;
  logic [CNT_W-1:0]     r_cnt,      w_cnt;
  logic                 r_wr,       w_wr;
  logic [NUM_REQ-1:0]   r_done,     w_done;
  logic                 r_err,      w_err;
  logic [15:0]          r_rd_data,  w_rd_data;
  logic                 r_busy,     w_busy;
  logic [2:0]           r_grant_id, w_grant_id;
  logic [4:0]           r_addr,     w_addr;
  logic [15:0]          r_wdata,    w_wdata;
  logic                 r_rd_req,   w_rd_req;
  logic                 r_wr_req,   w_wr_req;

  // Client vectors padded to 8 entries so a 3-bit index always fits.
  logic [7:0]           w_req_pad;
  logic [7:0]           w_wr_pad;
  logic [4:0]           w_addr_arr  [8];
  logic [15:0]          w_wdata_arr [8];
  logic                 w_any;
  logic [2:0]           w_sel;
  logic [NUM_REQ-1:0]   w_gnt_onehot;

  assign w_req_pad = 8'(req);
  assign w_wr_pad  = 8'(req_wr);

  for (genvar g = 0; g < 8; g++) begin : g_slice
    if (g < NUM_REQ) begin : g_used
      assign w_addr_arr[g]  = req_addr[5*g +: 5];
      assign w_wdata_arr[g] = req_wdata[16*g +: 16];
    end else begin : g_pad
      assign w_addr_arr[g]  = '0;
      assign w_wdata_arr[g] = '0;
    end
  end

  assign w_gnt_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_grant_id;

  function automatic logic [2:0] wrap_idx(input logic [2:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return s[2:0];
  endfunction

  // Round-robin pick: scan from the far end so the nearest requester at or
  // after the pointer is the last one written and therefore wins.
  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_req_pad[wrap_idx(r_ptr, k)]) begin
        w_any = 1'b1;
        w_sel = wrap_idx(r_ptr, k);
      end
    end
  end

  always_comb begin
    // NOTE: every variable gets its hold/default value first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    w_state    = r_state;
    w_ptr      = r_ptr;
    w_cnt      = r_cnt;
    w_wr       = r_wr;
    w_done     = '0;
    w_err      = 1'b0;
    w_rd_data  = r_rd_data;
    w_busy     = r_busy;
    w_grant_id = r_grant_id;
    w_addr     = r_addr;
    w_wdata    = r_wdata;
    w_rd_req   = r_rd_req;
    w_wr_req   = r_wr_req;

    // busy covers the done cycle itself and drops right after it.
    if (r_done != '0) w_busy = 1'b0;

    case (r_state)
      S_IDLE: begin
        // No grant during the done cycle: the finishing client still holds
        // req there, and only a req still high one cycle later is new.
        if (w_any && mdio_ready && (r_done == '0)) begin
          w_state    = S_WAIT_BUSY;
          w_ptr      = (w_sel == LAST_IDX) ? 3'd0 : w_sel + 3'd1;
          w_cnt      = '0;
          w_wr       = w_wr_pad[w_sel];
          w_addr     = w_addr_arr[w_sel];
          w_wdata    = w_wdata_arr[w_sel];
          w_grant_id = w_sel;
          w_busy     = 1'b1;
          w_rd_req   = ~w_wr_pad[w_sel];
          w_wr_req   = w_wr_pad[w_sel];
        end
      end

      S_WAIT_BUSY, S_WAIT_DONE: begin
        if (r_cnt == TIMEOUT_VAL) begin
          // Hung engine: report the abort directly, skipping FINISH.
          w_rd_req  = 1'b0;
          w_wr_req  = 1'b0;
          w_rd_data = 16'hFFFF;
          w_done    = w_gnt_onehot;
          w_err     = 1'b1;
          w_state   = S_IDLE;
        end else begin
          w_cnt = r_cnt + 1'b1;
          if (r_state == S_WAIT_BUSY) begin
            // Engine has accepted the request once it reports not-ready.
            if (!mdio_ready) begin
              w_rd_req = 1'b0;
              w_wr_req = 1'b0;
              w_state  = S_WAIT_DONE;
            end
          end else if (mdio_ready) begin
            if (!r_wr) w_rd_data = mdio_rd_data;
            w_state = S_FINISH;
          end
        end
      end

      S_FINISH: begin
        w_done  = w_gnt_onehot;
        w_state = S_IDLE;
      end

      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_cnt      <= '0;
      r_wr       <= 1'b0;
      r_done     <= '0;
      r_err      <= 1'b0;
      r_rd_data  <= '0;
      r_busy     <= 1'b0;
      r_grant_id <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rd_req   <= 1'b0;
      r_wr_req   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      r_state    <= w_state;
      r_ptr      <= w_ptr;
      r_cnt      <= w_cnt;
      r_wr       <= w_wr;
      r_done     <= w_done;
      r_err      <= w_err;
      r_rd_data  <= w_rd_data;
      r_busy     <= w_busy;
      r_grant_id <= w_grant_id;
      r_addr     <= w_addr;
      r_wdata    <= w_wdata;
      r_rd_req   <= w_rd_req;
      r_wr_req   <= w_wr_req;
    end
  end

  assign done            = r_done;
  assign err             = r_err;
  assign rd_data         = r_rd_data;
  assign busy            = r_busy;
  assign grant_id        = r_grant_id;
  assign mdio_addr       = r_addr;
  assign mdio_wr_data    = r_wdata;
  assign mdio_rd_request = r_rd_req;
  assign mdio_wr_request = r_wr_req;

endmodule

// File: tb/tb_mdio_arbiter.sv
// Self-checking bench for mdio_arbiter: a behavioural MDIO engine answers
// the handshake; a vector table covers single transactions and directed
// sequences cover round-robin, timeout, reset and mid-transaction changes.
module tb_mdio_arbiter;

  localparam int N       = 3;
  localparam int TO      = 16;
  localparam int ENG_LAT = 4;

  logic              clock;
  logic              reset;
  logic [N-1:0]      req;
  logic [N-1:0]      req_wr;
  logic [5*N-1:0]    req_addr;
  logic [16*N-1:0]   req_wdata;
  logic [N-1:0]      done;
  logic              err;
  logic [15:0]       rd_data;
  logic              busy;
  logic [2:0]        grant_id;
  logic [4:0]        mdio_addr;
  logic [15:0]       mdio_wr_data;
  logic              mdio_rd_request;
  logic              mdio_wr_request;
  logic              mdio_ready;
  logic [15:0]       mdio_rd_data;

  logic [4:0]        c_addr  [N];
  logic [15:0]       c_wdata [N];

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_addr[5*g +: 5]    = c_addr[g];
    assign req_wdata[16*g +: 16] = c_wdata[g];
  end

  mdio_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clock           (clock),
    .reset           (reset),
    .req             (req),
    .req_wr          (req_wr),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .done            (done),
    .err             (err),
    .rd_data         (rd_data),
    .busy            (busy),
    .grant_id        (grant_id),
    .mdio_addr       (mdio_addr),
    .mdio_wr_data    (mdio_wr_data),
    .mdio_rd_request (mdio_rd_request),
    .mdio_wr_request (mdio_wr_request),
    .mdio_ready      (mdio_ready),
    .mdio_rd_data    (mdio_rd_data)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Behavioural engine: accepts a request while ready, drops ready, then
  // raises it ENG_LAT cycles later (or holds it low while eng_hang is set).
  logic        eng_hang = 1'b0;
  logic [15:0] eng_rdata_next = '0;
  logic [4:0]  eng_addr = '0;
  logic [15:0] eng_wdata = '0;
  logic        eng_wr = 1'b0;
  logic        eng_req_after_drop = 1'b0;
  int          eng_rise_cyc = 0;

  initial begin
    mdio_ready   = 1'b1;
    mdio_rd_data = '0;
    forever begin
      @(negedge clock);
      if (mdio_ready && (mdio_rd_request || mdio_wr_request)) begin
        eng_addr   = mdio_addr;
        eng_wdata  = mdio_wr_data;
        eng_wr     = mdio_wr_request;
        mdio_ready = 1'b0;
        @(negedge clock);
        eng_req_after_drop = mdio_rd_request | mdio_wr_request;
        while (eng_hang) @(negedge clock);
        repeat (ENG_LAT) @(negedge clock);
        mdio_rd_data = eng_rdata_next;
        mdio_ready   = 1'b1;
        eng_rise_cyc = cyc;
      end
    end
  end

  int overlap     = 0;
  int done_pulses = 0;
  initial forever begin
    @(negedge clock);
    if (mdio_rd_request && mdio_wr_request) overlap++;
    if (done != '0) done_pulses++;
  end

  logic [N-1:0] got_done;
  logic         got_err;
  logic [15:0]  got_rd;
  logic [2:0]   got_gid;
  int           got_cyc;
  int           grant_cyc;

  task automatic wait_done(input int max_cyc, output bit seen);
    seen = 1'b0;
    for (int k = 0; k < max_cyc; k++) begin
      @(negedge clock);
      if (done != '0) begin
        seen     = 1'b1;
        got_done = done;
        got_err  = err;
        got_rd   = rd_data;
        got_gid  = grant_id;
        got_cyc  = cyc;
        break;
      end
    end
  endtask

  task automatic wait_busy(input int max_cyc, output bit seen);
    seen = 1'b0;
    for (int k = 0; k < max_cyc; k++) begin
      @(negedge clock);
      if (busy) begin
        seen      = 1'b1;
        grant_cyc = cyc;
        got_gid   = grant_id;
        break;
      end
    end
  endtask

  typedef struct {
    logic [1:0]   client;
    logic         wr;
    logic [4:0]   addr;
    logic [15:0]  wdata;
    logic [15:0]  eng_rdata;
    logic [15:0]  exp_rd;
    logic [N-1:0] exp_done;
  } vec_t;

  vec_t vecs [6];
  vec_t v;
  bit   seen;
  int   dp0;
  logic [N-1:0] exp_order [6];

  initial begin
    vecs[0] = '{2'd0, 1'b0, 5'h03, 16'h0000, 16'h1622, 16'h1622, 3'b001};
    vecs[1] = '{2'd1, 1'b1, 5'h0E, 16'h4002, 16'hDEAD, 16'h1622, 3'b010};
    vecs[2] = '{2'd2, 1'b0, 5'h1F, 16'h0000, 16'h0000, 16'h0000, 3'b100};
    vecs[3] = '{2'd1, 1'b0, 5'h00, 16'h3333, 16'hA5A5, 16'hA5A5, 3'b010};
    vecs[4] = '{2'd0, 1'b1, 5'h1F, 16'hFFFF, 16'h1234, 16'hA5A5, 3'b001};
    vecs[5] = '{2'd2, 1'b1, 5'h11, 16'h8001, 16'h5555, 16'hA5A5, 3'b100};
    exp_order = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

    reset  = 1'b1;
    req    = '0;
    req_wr = '0;
    for (int j = 0; j < N; j++) begin
      c_addr[j]  = '0;
      c_wdata[j] = '0;
    end

    // Reset values
    repeat (2) @(negedge clock);
    check("rst_flags", {29'd0, |done, err, busy}, 32'd0);
    check("rst_reqs", {30'd0, mdio_rd_request, mdio_wr_request}, 32'd0);
    check("rst_rd_data", rd_data, 32'h0);
    check("rst_grant_id", grant_id, 32'd0);
    check("rst_mdio_bus", {mdio_addr, mdio_wr_data}, 32'h0);
    reset = 1'b0;
    @(negedge clock);

    // Table: one client at a time
    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      eng_rdata_next    = v.eng_rdata;
      req_wr[v.client]  = v.wr;
      c_addr[v.client]  = v.addr;
      c_wdata[v.client] = v.wdata;
      req[v.client]     = 1'b1;
      wait_done(60, seen);
      req[v.client]     = 1'b0;
      check($sformatf("v%0d_done_seen", i), {31'd0, seen}, 32'd1);
      check($sformatf("v%0d_done", i), got_done, v.exp_done);
      check($sformatf("v%0d_err", i), got_err, 32'd0);
      check($sformatf("v%0d_rd_data", i), got_rd, v.exp_rd);
      check($sformatf("v%0d_grant_id", i), got_gid, v.client);
      check($sformatf("v%0d_eng_addr", i), eng_addr, v.addr);
      check($sformatf("v%0d_eng_op", i), eng_wr, v.wr);
      check($sformatf("v%0d_eng_wdata", i), eng_wdata, v.wdata);
      check($sformatf("v%0d_req_dropped", i), eng_req_after_drop, 32'd0);
      check($sformatf("v%0d_done_latency", i), got_cyc - eng_rise_cyc, 32'd2);
      @(negedge clock);
      check($sformatf("v%0d_idle_after", i), {30'd0, |done, busy}, 32'd0);
    end

    // Three clients requesting continuously: 0,1,2,0,1,2
    dp0 = done_pulses;
    eng_rdata_next = 16'h2222;
    for (int j = 0; j < N; j++) begin
      req_wr[j] = 1'b0;
      c_addr[j] = 5'(j + 4);
    end
    req = 3'b111;
    for (int i = 0; i < 6; i++) begin
      wait_done(60, seen);
      check($sformatf("rr%0d_done_seen", i), {31'd0, seen}, 32'd1);
      check($sformatf("rr%0d_done", i), got_done, exp_order[i]);
    end
    req = '0;
    repeat (3) @(negedge clock);
    check("rr_done_count", done_pulses - dp0, 32'd6);

    // Hung engine: abort 17 cycles after grant, then wait for ready
    eng_hang  = 1'b1;
    c_addr[0] = 5'h02;
    req[0]    = 1'b1;
    wait_busy(20, seen);
    check("to_grant_seen", {31'd0, seen}, 32'd1);
    wait_done(40, seen);
    req[0] = 1'b0;
    check("to_done_seen", {31'd0, seen}, 32'd1);
    check("to_latency", got_cyc - grant_cyc, 32'd17);
    check("to_done", got_done, 32'b001);
    check("to_err", got_err, 32'd1);
    check("to_rd_data", got_rd, 32'hFFFF);
    dp0       = done_pulses;
    c_addr[1] = 5'h07;
    req[1]    = 1'b1;
    repeat (10) @(negedge clock);
    check("to_no_grant", {30'd0, busy, mdio_rd_request}, 32'd0);
    check("to_no_done", done_pulses, dp0);
    eng_rdata_next = 16'h0BAD;
    eng_hang       = 1'b0;
    wait_busy(30, seen);
    check("to_next_grant_seen", {31'd0, seen}, 32'd1);
    check("to_next_grant_id", got_gid, 32'd1);
    check("to_next_after_ready", grant_cyc - eng_rise_cyc, 32'd1);
    wait_done(60, seen);
    req[1] = 1'b0;
    check("to_next_done", got_done, 32'b010);
    check("to_next_rd", {15'd0, got_err, got_rd}, 32'h0BAD);
    repeat (2) @(negedge clock);

    // Reset in WAIT_DONE
    eng_hang  = 1'b1;
    c_addr[2] = 5'h1A;
    req[2]    = 1'b1;
    wait_busy(20, seen);
    check("rs_grant_seen", {31'd0, seen}, 32'd1);
    repeat (3) @(negedge clock);
    dp0   = done_pulses;
    reset = 1'b1;
    #1;
    check("rs_async_flags", {29'd0, |done, busy, mdio_rd_request}, 32'd0);
    check("rs_async_rd_data", rd_data, 32'h0);
    check("rs_async_gid_addr", {grant_id, mdio_addr}, 32'h0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (8) @(negedge clock);
    check("rs_wait_ready", {31'd0, busy}, 32'd0);
    check("rs_no_done", done_pulses, dp0);
    eng_rdata_next = 16'h7E57;
    eng_hang       = 1'b0;
    wait_busy(30, seen);
    check("rs_regrant_seen", {31'd0, seen}, 32'd1);
    check("rs_regrant_after_ready", grant_cyc - eng_rise_cyc, 32'd1);
    check("rs_regrant_id", got_gid, 32'd2);
    wait_done(60, seen);
    req[2] = 1'b0;
    check("rs_done", got_done, 32'b100);
    check("rs_rd_data", got_rd, 32'h7E57);
    repeat (2) @(negedge clock);

    // Client 2 drops req and changes address after grant
    c_addr[2]      = 5'h09;
    eng_rdata_next = 16'hC0DE;
    req[2]         = 1'b1;
    wait_busy(20, seen);
    check("dr_grant_seen", {31'd0, seen}, 32'd1);
    req[2]    = 1'b0;
    c_addr[2] = 5'h15;
    wait_done(60, seen);
    check("dr_done_seen", {31'd0, seen}, 32'd1);
    check("dr_done", got_done, 32'b100);
    check("dr_eng_addr", eng_addr, 32'h09);
    check("dr_mdio_addr", mdio_addr, 32'h09);
    check("dr_rd_data", got_rd, 32'hC0DE);
    repeat (2) @(negedge clock);

    check("no_request_overlap", overlap, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
